// File: rtl/pipelined_add_arbiter.sv
// pipelined_add_arbiter: shares one pipelined adder among NUM_REQ requesters, tagging each op to route its result back.
// Define PIPE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module pipelined_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     add_valid,
  output logic [WIDTH-1:0]         add_data,
  input  logic [WIDTH-1:0]         add_result,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);
  logic [ID_W-1:0] r_ptr, r_add_id, w_gnt, w_idx, w_ptr_nxt;
  logic            w_any;
  logic [LATENCY-1:0] r_tag_v;
  logic [ID_W-1:0] r_tag_id [LATENCY];
  // scan from the far end so the requester nearest ptr wins
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_gnt = w_idx;
        w_any = 1'b1;
      end
    end
  end
  assign req_ready = w_any ? NUM_REQ'(1) << w_gnt : '0;
`ifdef PIPE_ARB_FIXED_PRIO_EN
  assign w_ptr_nxt = '0;
`else
  assign w_ptr_nxt = !w_any ? r_ptr : (int'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      add_valid <= 1'b0;
      add_data  <= '0;
      r_add_id  <= '0;
      r_tag_v   <= '0;
      r_tag_id  <= '{default: '0};
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      add_valid   <= w_any;
      add_data    <= w_any ? req_data[int'(w_gnt)*WIDTH +: WIDTH] : '0;
      r_add_id    <= w_any ? w_gnt : '0;
      r_tag_v[0]  <= add_valid;
      r_tag_id[0] <= r_add_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      rsp_valid <= r_tag_v[LATENCY-1];
      rsp_id    <= r_tag_v[LATENCY-1] ? r_tag_id[LATENCY-1] : '0;
      rsp_data  <= r_tag_v[LATENCY-1] ? add_result : '0;
    end
  end
  assign busy = add_valid | (|r_tag_v) | rsp_valid;
endmodule

// File: tb/tb_pipelined_add_arbiter.sv
// tb_pipelined_add_arbiter: directed vector table plus random traffic against a cycle-history reference model.
module tb_pipelined_add_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_data;
  logic        add_valid, rsp_valid, busy;
  logic [15:0] add_data, add_result, rsp_data;
  logic [1:0]  rsp_id;

  pipelined_add_arbiter #(.NUM_REQ(4), .WIDTH(16), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .add_valid(add_valid), .add_data(add_data), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  // stand-in for pipelined_adds: result = in + 2, one edge of latency
  always_ff @(posedge clk) add_result <= add_data + 16'd2;

`ifdef PIPE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    logic rst; logic [3:0] vld; logic [63:0] dat;
    logic [3:0] rdy; logic av; logic [15:0] ad; logic rv; logic [1:0] rid; logic [15:0] rd; logic bsy;
  } vec_t;
  vec_t tbl[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_ptr = 0, m_last_g = -1, cur_g = -1;
  logic cur_r;
  logic [63:0] cur_d;
  logic        h_v [64];
  logic [1:0]  h_id [64];
  logic [15:0] h_d [64];
  logic [3:0]  rv_v;
  logic [63:0] rv_d;

  function automatic vec_t mk(logic r, logic [3:0] v, logic [63:0] d, logic [3:0] rdy, logic av,
                              logic [15:0] ad, logic rv, logic [1:0] rid, logic [15:0] rd, logic b);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = d; t.rdy = rdy; t.av = av; t.ad = ad;
    t.rv = rv; t.rid = rid; t.rd = rd; t.bsy = b;
    return t;
  endfunction

  function automatic int pick(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [3:0] v, logic [63:0] d);
    int i1, i3;
    @(negedge clk);
    rst = r; req_valid = v; req_data = d;
    #1;
    cur_r = r; cur_d = d;
    cur_g = pick(v, FIXED ? 0 : m_ptr);
    i1 = (cyc - 1) & 63;
    i3 = (cyc - 3) & 63;
    chk("m_ready", req_ready, cur_g < 0 ? 0 : (1 << cur_g));
    chk("m_add_valid", add_valid, h_v[i1]);
    chk("m_add_data", add_data, h_v[i1] ? h_d[i1] : 16'd0);
    chk("m_rsp_valid", rsp_valid, h_v[i3]);
    chk("m_rsp_id", rsp_id, h_v[i3] ? h_id[i3] : 2'd0);
    chk("m_rsp_data", rsp_data, h_v[i3] ? 16'(h_d[i3] + 16'd2) : 16'd0);
    chk("m_busy", busy, h_v[i1] | h_v[(cyc - 2) & 63] | h_v[i3]);
  endtask

  task automatic advance();
    @(posedge clk);
    if (cur_r) begin
      foreach (h_v[i]) h_v[i] = 1'b0;
      m_ptr = 0;
      m_last_g = -1;
    end else begin
      h_v[cyc & 63]  = cur_g >= 0;
      h_id[cyc & 63] = 2'(cur_g < 0 ? 0 : cur_g);
      h_d[cyc & 63]  = cur_g < 0 ? 16'd0 : cur_d[cur_g*16 +: 16];
      if (cur_g >= 0 && !FIXED) m_ptr = (cur_g + 1) % 4;
      m_last_g = cur_g;
    end
    cyc++;
  endtask

  initial begin
    logic [63:0] rr, sg, mf;
    rr = {16'd400, 16'd300, 16'd200, 16'd100};
    sg = {16'd0, 16'd10, 16'd0, 16'd0};
    mf = {16'd0, 16'd0, 16'd0, 16'd15};
    foreach (h_v[i]) h_v[i] = 1'b0;
    rst = 1'b1; req_valid = 4'hF; req_data = rr;
    @(posedge clk);
`ifndef PIPE_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(1, 4'b1111, rr, 4'b0001, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 4'b0000, rr, 4'b0000, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 4'b0100, sg, 4'b0100, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 4'b0000, sg, 4'b0000, 1, 10,  0, 0, 0,   1));
    tbl.push_back(mk(0, 4'b0000, sg, 4'b0000, 0, 0,   0, 0, 0,   1));
    tbl.push_back(mk(0, 4'b0000, sg, 4'b0000, 0, 0,   1, 2, 12,  1));
    tbl.push_back(mk(0, 4'b0000, sg, 4'b0000, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(1, 4'b0000, rr, 4'b0000, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 4'b1111, rr, 4'b0001, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 4'b1111, rr, 4'b0010, 1, 100, 0, 0, 0,   1));
    tbl.push_back(mk(0, 4'b1111, rr, 4'b0100, 1, 200, 0, 0, 0,   1));
    tbl.push_back(mk(0, 4'b1111, rr, 4'b1000, 1, 300, 1, 0, 102, 1));
    tbl.push_back(mk(0, 4'b1111, rr, 4'b0001, 1, 400, 1, 1, 202, 1));
    tbl.push_back(mk(0, 4'b1111, rr, 4'b0010, 1, 100, 1, 2, 302, 1));
    tbl.push_back(mk(0, 4'b1111, rr, 4'b0100, 1, 200, 1, 3, 402, 1));
    tbl.push_back(mk(0, 4'b1111, rr, 4'b1000, 1, 300, 1, 0, 102, 1));
    tbl.push_back(mk(0, 4'b0000, rr, 4'b0000, 1, 400, 1, 1, 202, 1));
    tbl.push_back(mk(0, 4'b0000, rr, 4'b0000, 0, 0,   1, 2, 302, 1));
    tbl.push_back(mk(0, 4'b0000, rr, 4'b0000, 0, 0,   1, 3, 402, 1));
    tbl.push_back(mk(0, 4'b0000, rr, 4'b0000, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 4'b1010, rr, 4'b0010, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 4'b1010, rr, 4'b1000, 1, 200, 0, 0, 0,   1));
    tbl.push_back(mk(0, 4'b1010, rr, 4'b0010, 1, 400, 0, 0, 0,   1));
    tbl.push_back(mk(0, 4'b1010, rr, 4'b1000, 1, 200, 1, 1, 202, 1));
    tbl.push_back(mk(0, 4'b0001, mf, 4'b0001, 1, 400, 1, 3, 402, 1));
    tbl.push_back(mk(1, 4'b0000, mf, 4'b0000, 1, 15,  1, 1, 202, 1));
    tbl.push_back(mk(0, 4'b0000, mf, 4'b0000, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 4'b0000, mf, 4'b0000, 0, 0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 4'b0000, mf, 4'b0000, 0, 0,   0, 0, 0,   0));
    foreach (tbl[n]) begin
      drive(tbl[n].rst, tbl[n].vld, tbl[n].dat);
      chk("t_ready", req_ready, tbl[n].rdy);
      chk("t_add_valid", add_valid, tbl[n].av);
      chk("t_add_data", add_data, tbl[n].ad);
      chk("t_rsp_valid", rsp_valid, tbl[n].rv);
      chk("t_rsp_id", rsp_id, tbl[n].rid);
      chk("t_rsp_data", rsp_data, tbl[n].rd);
      chk("t_busy", busy, tbl[n].bsy);
      advance();
    end
`else
    drive(1'b1, 4'b1111, rr);
    chk("f_reset_ready", req_ready, 4'b0001);
    advance();
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, 4'b1001, rr);
      chk("f_hold_low", req_ready, 4'b0001);
      advance();
    end
    for (int n = 0; n < 2; n++) begin
      drive(1'b0, 4'b1000, rr);
      chk("f_high_only", req_ready, 4'b1000);
      advance();
    end
`endif
    rv_v = '0;
    rv_d = '0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!rv_v[i] || m_last_g == i) begin
          rv_v[i] = $urandom_range(0, 2) != 0;
          rv_d[i*16 +: 16] = 16'($urandom);
        end else if ($urandom_range(0, 7) == 0) rv_v[i] = 1'b0;
      end
      drive($urandom_range(0, 39) == 0, rv_v, rv_d);
      advance();
    end
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 4'b0000, rv_d);
      advance();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_add_arbiter.md
# pipelined_add_arbiter

Round-robin arbiter that shares one `pipelined_adds` datapath between `NUM_REQ` requesters. It accepts at most one operand per cycle and drives the adder's `in_valid`/`in_data`. It tracks every in-flight operation with a tag shift register matched to the adder latency, then returns each `result` to the issuing requester with its ID. It sits between the requesting units and the shared adder instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 16: operand/result width.
- `LATENCY`, default 1: adder latency in clock edges, from sampling `in_valid`/`in_data` to a valid `result`; ≥1.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: bit i = requester i has an operand.
- `req_data` in NUM_REQ*WIDTH: operand i occupies bits [i*WIDTH +: WIDTH].
- `req_ready` out NUM_REQ: one-hot grant, combinational.
- `add_valid` out 1: connects to adder `in_valid`, registered.
- `add_data` out WIDTH: connects to adder `in_data`, registered.
- `add_result` in WIDTH: connects to adder `result`.
- `rsp_valid` out 1: response valid, registered.
- `rsp_id` out ID_W: requester the response belongs to.
- `rsp_data` out WIDTH: adder result for that requester.
- `busy` out 1: high while any operation is in flight (`add_valid`, the tag pipe, or `rsp_valid`).

## Operation
- **Arbitration:**
  - A round-robin pointer `ptr` (ID_W bits) names the highest-priority requester.
  - The grant goes to the first i with `req_valid[i]=1`, scanning `ptr`, `ptr+1`, …, modulo NUM_REQ.
  - `req_ready` is 0 when no request is valid.
- **Transfer:** occurs when `req_valid[i] & req_ready[i]`, at most one per cycle. No backpressure: the adder accepts every cycle.
- **Pointer update:** on a transfer by requester g, `ptr <= (g+1) mod NUM_REQ`. With no transfer, `ptr` holds. Wrap: g = NUM_REQ-1 sets `ptr` to 0.
- **Issue register:** on a transfer, `add_valid <= 1` and `add_data <= req_data[g]`. Otherwise `add_valid <= 0` and `add_data <= 0`.
- **Tag pipe:**
  - LATENCY stages of {valid, id}.
  - Stage 0 loads {`add_valid`, id of the operand in the issue register}; each stage shifts one per cycle.
  - The last stage lines up with the cycle in which `add_result` is valid.
- **Response register:**
  - `rsp_valid <= tag_valid_last` and `rsp_id <= tag_id_last`.
  - `rsp_data <= tag_valid_last ? add_result : 0`.
  - With `rsp_valid=0`, `rsp_id` and `rsp_data` are 0.
- **Responses:** no response backpressure; the consumer must sink one response per cycle.
- **Ordering:** responses leave in issue order; IDs may interleave.

## Timing
- **Reset values:**
  - `ptr`=0, all tag stages invalid, `add_valid`=0, `add_data`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0.
  - `req_ready` follows `req_valid` with `ptr`=0 (combinational).
- **Reset mid-operation:** all in-flight operations are dropped. No response is emitted for them, even though the adder may still output results.
- **Latency:**
  - Handshake in cycle A gives `add_valid` in cycle A+1 and `rsp_valid` in cycle A+2+LATENCY.
  - With LATENCY=1, the response is in cycle A+3.
- **Throughput:** one operation per cycle sustained; back-to-back grants to different requesters are allowed.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,2,3,0,… Each requester waits at most NUM_REQ-1 cycles.
- **Request changes:** `req_valid` may drop without a grant; requesters must hold `req_data` stable while valid.

## Configuration
- `PIPE_ARB_FIXED_PRIO_EN`
  - **Defined:** fixed priority; the lowest index among valid requests wins. `ptr` is held at 0 and not updated.
  - **Undefined (default):** round-robin as above.
  - Ports, latency and response path are identical in both builds.

## Test plan
All cases use `pipelined_adds` as the datapath (result = in + 2, LATENCY=1).
- **Reset:** assert `rst` for 2 cycles with all `req_valid`=1.
  - All outputs match the reset values, then `req_ready`=0001.
- **Single op:** requester 2 sends 10 in cycle A.
  - `req_ready`=0100 in cycle A.
  - Cycle A+1: `add_valid`=1, `add_data`=10.
  - Cycle A+3: `rsp_valid`=1, `rsp_id`=2, `rsp_data`=12.
  - Next cycle: `rsp_valid`=0, `rsp_data`=0, `busy`=0.
- **Round-robin:** all 4 requesters valid with data 100,200,300,400 for 8 cycles.
  - Grant order 0,1,2,3,0,1,2,3.
  - Responses, back-to-back: (0,102),(1,202),(2,302),(3,402),…
- **Wrap and skip:** only requesters 1 and 3 valid, starting from `ptr`=0.
  - Grants alternate 1,3,1,3; `ptr` wraps 3→0 after each grant to 3.
- **Reset mid-flight:** issue 15 from requester 0, then assert `rst` one cycle later.
  - No `rsp_valid` pulse appears for it; `busy`=0 after reset.
- **Fixed priority:** `PIPE_ARB_FIXED_PRIO_EN` defined, requesters 0 and 3 continuously valid.
  - Requester 0 is granted every cycle; requester 3 is never granted until requester 0 drops `req_valid`.
